// File: rtl/pipe_adder.sv
// ============================================================================
// Module   : pipe_adder
// Brief    : Two-stage registered unsigned adder, WIDTH-bit operands to a
//            WIDTH+1-bit sum, plus a pipeline fill flag.
//            Optional macro PIPE_ADDER_CARRY_SPLIT_EN splits the add across
//            both stages (low half + carry first, high half second).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_adder #(
    parameter int WIDTH   = 8,
    parameter int LATENCY = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH:0]   sum,
    output logic             fill_valid
);

    generate
        if (LATENCY != 2) begin : g_latency_check
            $error("pipe_adder: LATENCY must be 2");
        end
    endgenerate

    logic [WIDTH:0] sum_d;
    logic [WIDTH:0] sum_q;
    logic [1:0]     fill_d;
    logic [1:0]     fill_q;

`ifdef PIPE_ADDER_CARRY_SPLIT_EN
    localparam int c_LO_W = (WIDTH + 1) / 2;
    localparam int c_HI_W = WIDTH - c_LO_W;

    logic [c_LO_W:0]   w_lo_full;
    logic [c_HI_W:0]   w_hi_full;
    logic [c_LO_W-1:0] lo_d;
    logic [c_LO_W-1:0] lo_q;
    logic              carry_d;
    logic              carry_q;
    logic [c_HI_W-1:0] ah_d;
    logic [c_HI_W-1:0] ah_q;
    logic [c_HI_W-1:0] bh_d;
    logic [c_HI_W-1:0] bh_q;

    always_comb begin
        w_lo_full = {1'b0, a[c_LO_W-1:0]} + {1'b0, b[c_LO_W-1:0]};
        lo_d      = w_lo_full[c_LO_W-1:0];
        carry_d   = w_lo_full[c_LO_W];
        ah_d      = a[WIDTH-1:c_LO_W];
        bh_d      = b[WIDTH-1:c_LO_W];
        // Upper halves absorb the low-half carry, then rejoin the low bits.
        w_hi_full = {1'b0, ah_q} + {1'b0, bh_q} + {{c_HI_W{1'b0}}, carry_q};
        sum_d     = {w_hi_full, lo_q};
        fill_d    = {fill_q[0], 1'b1};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lo_q    <= '0;
            carry_q <= 1'b0;
            ah_q    <= '0;
            bh_q    <= '0;
            sum_q   <= '0;
            fill_q  <= '0;
        end else begin
            lo_q    <= lo_d;
            carry_q <= carry_d;
            ah_q    <= ah_d;
            bh_q    <= bh_d;
            sum_q   <= sum_d;
            fill_q  <= fill_d;
        end
    end
`else
    logic [WIDTH-1:0] a_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_d;
    logic [WIDTH-1:0] b_q;

    always_comb begin
        a_d    = a;
        b_d    = b;
        sum_d  = {1'b0, a_q} + {1'b0, b_q};
        fill_d = {fill_q[0], 1'b1};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            sum_q  <= '0;
            fill_q <= '0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            sum_q  <= sum_d;
            fill_q <= fill_d;
        end
    end
`endif

    assign sum        = sum_q;
    assign fill_valid = fill_q[1];

endmodule

`default_nettype wire

// File: tb/tb_pipe_adder.sv
// ============================================================================
// Module   : tb_pipe_adder
// Brief    : Scoreboard bench for pipe_adder (either carry-split mode).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_adder;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH:0]   sum;
    logic             fill_valid;

    int n_checks;
    int n_errors;

    // Stage-1 contents in flight: entry pushed at each edge, popped one edge later.
    logic [WIDTH:0] sb_q[$];
    int             run_len;

    pipe_adder #(
        .WIDTH  (WIDTH),
        .LATENCY(2)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .sum       (sum),
        .fill_valid(fill_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cycle(input logic [WIDTH-1:0] ra, input logic [WIDTH-1:0] rb,
                         input logic rr, input string tag);
        logic [WIDTH:0] front;
        logic [WIDTH:0] exp_sum;
        logic           exp_fill;
        @(negedge clk);
        a   = ra;
        b   = rb;
        rst = rr;
        @(posedge clk);
        front = sb_q.pop_front();
        sb_q.push_back(rr ? '0 : ({1'b0, ra} + {1'b0, rb}));
        exp_sum = rr ? '0 : front;
        if (rr) run_len = 0;
        else if (run_len < 2) run_len++;
        exp_fill = (run_len >= 2);
        #1;
        chk({tag, ".sum"}, 32'(sum), 32'(exp_sum));
        chk({tag, ".fill"}, 32'(fill_valid), 32'(exp_fill));
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        run_len  = 0;
        sb_q.push_back('0);
        a   = '0;
        b   = '0;
        rst = 1'b1;

        cycle(8'd77, 8'd91, 1'b1, "reset0");
        cycle(8'd200, 8'd13, 1'b1, "reset1");

        cycle(8'd10, 8'd20, 1'b0, "stream0");
        cycle(8'd15, 8'd25, 1'b0, "stream1");
        cycle(8'd30, 8'd40, 1'b0, "stream2");
        cycle(8'd50, 8'd60, 1'b0, "stream3");
        cycle(8'd255, 8'd255, 1'b0, "stream4");
        cycle(8'd255, 8'd1, 1'b0, "cmax");
        cycle(8'd0, 8'd0, 1'b0, "cmsb");
        cycle(8'd100, 8'd100, 1'b0, "czero");
        cycle(8'd1, 8'd2, 1'b0, "mid0");
        cycle(8'd0, 8'd0, 1'b1, "midrst");
        cycle(8'd7, 8'd8, 1'b0, "post0");
        cycle(8'd0, 8'd0, 1'b0, "post1");

        for (int i = 0; i < 6; i++) cycle(8'd128, 8'd127, 1'b0, "held");

        // Spot-check the direct values the scoreboard relies on.
        cycle(8'd255, 8'd255, 1'b0, "edge0");
        cycle(8'd0, 8'd0, 1'b0, "edge1");
        chk("max_sum", 32'(sum), 32'd510);

        for (int i = 0; i < 1000; i++) begin
            cycle(WIDTH'($urandom_range(0, 255)), WIDTH'($urandom_range(0, 255)),
                  ($urandom_range(0, 63) == 0), "rand");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
